// File: rtl/correlator_pkg.sv
// Shared definitions for the correlator host command path: sync byte, register map,
// baud helper and the FSM state encodings used by the UART receiver blocks.
package correlator_pkg;

    localparam logic [7:0] CMD_SYNC_BYTE = 8'hA5;

    localparam int REG_INTEG_LEN  = 0;
    localparam int REG_SAMPLE_DIV = 1;
    localparam int REG_MODE       = 2;
    localparam int REG_SPARE      = 3;

    function automatic int clks_per_bit(input int clkHz, input int baud);
        return clkHz / baud;
    endfunction

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK
    } rx_state_t;

    typedef enum logic [2:0] {
        PKT_SYNC, PKT_ADDR, PKT_D3, PKT_D2, PKT_D1, PKT_D0, PKT_SUM
    } pkt_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop RX synchroniser plus mid-bit sampling byte FSM.
module uart_rx_byte
    import correlator_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_error_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rxMeta_q, rxSync_q;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byteValid_q, byteValid_d;
    logic [7:0]       byteData_q, byteData_d;
    logic             frameError_q, frameError_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta_q     <= 1'b1;
            rxSync_q     <= 1'b1;
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bitIdx_q     <= '0;
            shift_q      <= '0;
            byteValid_q  <= 1'b0;
            byteData_q   <= '0;
            frameError_q <= 1'b0;
        end else begin
            rxMeta_q     <= rx_i;
            rxSync_q     <= rxMeta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bitIdx_q     <= bitIdx_d;
            shift_q      <= shift_d;
            byteValid_q  <= byteValid_d;
            byteData_q   <= byteData_d;
            frameError_q <= frameError_d;
        end
    end

    // The line is always high when entering IDLE (BREAK waits for it), so a low level
    // here is the start-bit falling edge; this keeps back-to-back bytes from being lost.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bitIdx_d     = bitIdx_q;
        shift_d      = shift_q;
        byteValid_d  = 1'b0;
        byteData_d   = byteData_q;
        frameError_d = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rxSync_q) begin
                    state_d = RX_START;
                    cnt_d   = HALF_RELOAD;
                end
            end
            RX_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rxSync_q) begin
                    state_d  = RX_DATA;
                    cnt_d    = FULL_RELOAD;
                    bitIdx_d = '0;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d  = {rxSync_q, shift_q[7:1]};
                    cnt_d    = FULL_RELOAD;
                    bitIdx_d = bitIdx_q + 1'b1;
                    if (bitIdx_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxSync_q) begin
                    byteValid_d = 1'b1;
                    byteData_d  = shift_q;
                    state_d     = RX_IDLE;
                end else begin
                    frameError_d = 1'b1;
                    state_d      = RX_BREAK;
                end
            end
            RX_BREAK: begin
                if (rxSync_q) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_valid_o  = byteValid_q;
    assign byte_data_o   = byteData_q;
    assign frame_error_o = frameError_q;

endmodule

// File: rtl/uart_cmd_receiver.sv
// Host command receiver: UART bytes -> framed register-write packets
// (A5, addr, D3..D0, checksum) for the correlator configuration registers.
module uart_cmd_receiver
    import correlator_pkg::*;
#(
    parameter int CLK_FREQUENCY = 50000000,
    parameter int BAUD_RATE     = 230400,
    parameter int NUM_REGS      = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int TIMEOUT_BITS  = 40
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        RX,
    output logic                        byte_valid,
    output logic [7:0]                  byte_data,
    output logic                        cmd_valid,
    output logic [$clog2(NUM_REGS)-1:0] cmd_addr,
    output logic [DATA_WIDTH-1:0]       cmd_data,
    output logic                        frame_error,
    output logic                        cmd_error
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQUENCY, BAUD_RATE);
    localparam int ADDR_W       = $clog2(NUM_REGS);
    localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int GAP_W        = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [7:0]       NUM_REGS_B   = 8'(NUM_REGS);
    localparam logic [GAP_W-1:0] GAP_LIMIT    = GAP_W'(TIMEOUT_CLKS);

    logic       rxByteValid, rxFrameError;
    logic [7:0] rxByte;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (RX),
        .byte_valid_o (rxByteValid),
        .byte_data_o  (rxByte),
        .frame_error_o(rxFrameError)
    );

    pkt_state_t            state_q, state_d;
    logic [7:0]            sum_q, sum_d;
    logic [7:0]            addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  cmdValid_q, cmdValid_d;
    logic                  cmdError_q, cmdError_d;
    logic [ADDR_W-1:0]     cmdAddr_q, cmdAddr_d;
    logic [DATA_WIDTH-1:0] cmdData_q, cmdData_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PKT_SYNC;
            sum_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            gap_q      <= '0;
            cmdValid_q <= 1'b0;
            cmdError_q <= 1'b0;
            cmdAddr_q  <= '0;
            cmdData_q  <= '0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            gap_q      <= gap_d;
            cmdValid_q <= cmdValid_d;
            cmdError_q <= cmdError_d;
            cmdAddr_q  <= cmdAddr_d;
            cmdData_q  <= cmdData_d;
        end
    end

    // Frame errors abort the packet; the gap counter runs only while a packet is open.
    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        addr_d     = addr_q;
        data_d     = data_q;
        gap_d      = gap_q;
        cmdValid_d = 1'b0;
        cmdError_d = 1'b0;
        cmdAddr_d  = cmdAddr_q;
        cmdData_d  = cmdData_q;
        if (rxFrameError) begin
            state_d = PKT_SYNC;
            gap_d   = '0;
        end else if (rxByteValid) begin
            gap_d = '0;
            case (state_q)
                PKT_SYNC: if (rxByte == CMD_SYNC_BYTE) state_d = PKT_ADDR;
                PKT_ADDR: begin
                    addr_d  = rxByte;
                    sum_d   = rxByte;
                    state_d = PKT_D3;
                end
                PKT_D3, PKT_D2, PKT_D1, PKT_D0: begin
                    data_d = {data_q[DATA_WIDTH-9:0], rxByte};
                    sum_d  = sum_q + rxByte;
                    case (state_q)
                        PKT_D3:  state_d = PKT_D2;
                        PKT_D2:  state_d = PKT_D1;
                        PKT_D1:  state_d = PKT_D0;
                        default: state_d = PKT_SUM;
                    endcase
                end
                PKT_SUM: begin
                    if (rxByte == sum_q && addr_q < NUM_REGS_B) begin
                        cmdValid_d = 1'b1;
                        cmdAddr_d  = addr_q[ADDR_W-1:0];
                        cmdData_d  = data_q;
                    end else begin
                        cmdError_d = 1'b1;
                    end
                    state_d = PKT_SYNC;
                end
                default: state_d = PKT_SYNC;
            endcase
        end else if (state_q != PKT_SYNC) begin
            if (gap_q == GAP_LIMIT) begin
                state_d = PKT_SYNC;
                gap_d   = '0;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end
    end

    assign byte_valid  = rxByteValid;
    assign byte_data   = rxByte;
    assign frame_error = rxFrameError;
    assign cmd_valid   = cmdValid_q;
    assign cmd_error   = cmdError_q;
    assign cmd_addr    = cmdAddr_q;
    assign cmd_data    = cmdData_q;

endmodule

// File: tb/tb_uart_cmd_receiver.sv
// Self-checking bench for uart_cmd_receiver: table of packets plus directed
// sequences for frame error, start glitch, inter-byte timeout and mid-packet reset.
module tb_uart_cmd_receiver;

    // Baud kept at 230400; the clock is scaled so one bit is 30 cycles to keep runs short.
    localparam int CLK_FREQ = 6912000;
    localparam int BAUD     = 230400;
    localparam int CPB      = 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        cmd_valid;
    logic [1:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        frame_error;
    logic        cmd_error;

    always #10 clk = ~clk;

    uart_cmd_receiver #(
        .CLK_FREQUENCY(CLK_FREQ),
        .BAUD_RATE    (BAUD),
        .NUM_REGS     (4),
        .DATA_WIDTH   (32),
        .TIMEOUT_BITS (40)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .cmd_valid  (cmd_valid),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .frame_error(frame_error),
        .cmd_error  (cmd_error)
    );

    int checks = 0;
    int errors = 0;
    int nByteValid = 0, nCmdValid = 0, nCmdError = 0, nFrameError = 0, violations = 0;
    logic [7:0]  lastByte = 8'h00;
    logic [1:0]  prevAddr = 2'd0;
    logic [31:0] prevData = 32'd0;
    logic        prevRst  = 1'b0;

    // Pulse counters plus continuous checks for pulse exclusivity and held cmd_* values.
    always @(negedge clk) begin
        if (byte_valid) begin
            nByteValid = nByteValid + 1;
            lastByte   = byte_data;
        end
        if (cmd_valid)   nCmdValid   = nCmdValid + 1;
        if (cmd_error)   nCmdError   = nCmdError + 1;
        if (frame_error) nFrameError = nFrameError + 1;
        if ((32'(byte_valid) + 32'(cmd_valid) + 32'(cmd_error) + 32'(frame_error)) > 32'd1)
            violations = violations + 1;
        if (rst_n && prevRst && !cmd_valid && (cmd_addr != prevAddr || cmd_data != prevData))
            violations = violations + 1;
        prevAddr = cmd_addr;
        prevData = cmd_data;
        prevRst  = rst_n;
    end

    typedef struct {
        logic [55:0] seq;
        logic        expValid;
        logic        expError;
        logic [1:0]  expAddr;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[5];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic sendBit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(b[i]);
        sendBit(stopBit);
        rx = 1'b1;
    endtask

    task automatic applyStimulus(input logic [55:0] seq);
        for (int i = 0; i < 7; i++) sendByte(seq[55-8*i -: 8], 1'b1);
        repeat (5) @(posedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        @(negedge clk);
        checkOutput({tag, " byte_valid"},  32'(byte_valid),  32'd0);
        checkOutput({tag, " byte_data"},   32'(byte_data),   32'd0);
        checkOutput({tag, " cmd_valid"},   32'(cmd_valid),   32'd0);
        checkOutput({tag, " cmd_addr"},    32'(cmd_addr),    32'd0);
        checkOutput({tag, " cmd_data"},    cmd_data,         32'd0);
        checkOutput({tag, " frame_error"}, 32'(frame_error), 32'd0);
        checkOutput({tag, " cmd_error"},   32'(cmd_error),   32'd0);
    endtask

    int b0, c0, e0, f0;

    task automatic snap();
        b0 = nByteValid; c0 = nCmdValid; e0 = nCmdError; f0 = nFrameError;
    endtask

    initial begin
        vecs[0] = '{56'hA5_01_00_00_03_E8_EC, 1'b1, 1'b0, 2'd1, 32'h0000_03E8};
        vecs[1] = '{56'hA5_01_00_00_03_E8_ED, 1'b0, 1'b1, 2'd1, 32'h0000_03E8};
        vecs[2] = '{56'hA5_04_00_00_00_01_05, 1'b0, 1'b1, 2'd1, 32'h0000_03E8};
        vecs[3] = '{56'hA5_03_A5_12_34_56_44, 1'b1, 1'b0, 2'd3, 32'hA512_3456};
        vecs[4] = '{56'hA5_00_FF_FF_FF_FF_FC, 1'b1, 1'b0, 2'd0, 32'hFFFF_FFFF};

        repeat (3) @(posedge clk);
        checkResetOutputs("reset");
        @(posedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        for (int i = 0; i < 5; i++) begin
            snap();
            applyStimulus(vecs[i].seq);
            checkOutput($sformatf("vec%0d bytes", i),     32'(nByteValid - b0), 32'd7);
            checkOutput($sformatf("vec%0d lastbyte", i),  32'(lastByte),        32'(vecs[i].seq[7:0]));
            checkOutput($sformatf("vec%0d cmd_valid", i), 32'(nCmdValid - c0),  32'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d cmd_error", i), 32'(nCmdError - e0),  32'(vecs[i].expError));
            checkOutput($sformatf("vec%0d cmd_addr", i),  32'(cmd_addr),        32'(vecs[i].expAddr));
            checkOutput($sformatf("vec%0d cmd_data", i),  cmd_data,             vecs[i].expData);
        end

        // Stop bit low while idle: frame error only.
        snap();
        sendByte(8'h55, 1'b0);
        repeat (2*CPB) @(posedge clk);
        checkOutput("ferr pulses", 32'(nFrameError - f0), 32'd1);
        checkOutput("ferr bytes",  32'(nByteValid - b0),  32'd0);

        // Frame error inside a packet aborts it; the following packet must decode.
        snap();
        sendByte(8'hA5, 1'b1);
        sendByte(8'h03, 1'b1);
        sendByte(8'h55, 1'b0);
        repeat (2*CPB) @(posedge clk);
        applyStimulus(56'hA5_02_00_00_00_07_09);
        checkOutput("abort ferr",      32'(nFrameError - f0), 32'd1);
        checkOutput("abort cmd_valid", 32'(nCmdValid - c0),   32'd1);
        checkOutput("abort cmd_error", 32'(nCmdError - e0),   32'd0);
        checkOutput("abort cmd_data",  cmd_data,              32'h0000_0007);

        // 8-clock low glitch on idle line, then a clean byte.
        snap();
        rx = 1'b0;
        repeat (8) @(posedge clk);
        rx = 1'b1;
        repeat (3*CPB) @(posedge clk);
        checkOutput("glitch bytes", 32'(nByteValid - b0),  32'd0);
        checkOutput("glitch ferr",  32'(nFrameError - f0), 32'd0);
        sendByte(8'h3C, 1'b1);
        repeat (5) @(posedge clk);
        checkOutput("post-glitch bytes", 32'(nByteValid - b0), 32'd1);
        checkOutput("post-glitch data",  32'(lastByte),        32'h3C);

        // Partial packet, 50 bit-time gap, then full packet.
        snap();
        sendByte(8'hA5, 1'b1);
        sendByte(8'h02, 1'b1);
        sendByte(8'h00, 1'b1);
        repeat (50*CPB) @(posedge clk);
        applyStimulus(56'hA5_02_00_00_01_00_03);
        checkOutput("timeout cmd_valid", 32'(nCmdValid - c0), 32'd1);
        checkOutput("timeout cmd_error", 32'(nCmdError - e0), 32'd0);
        checkOutput("timeout cmd_addr",  32'(cmd_addr),       32'd2);
        checkOutput("timeout cmd_data",  cmd_data,            32'h0000_0100);

        // Reset while the D1 byte is arriving.
        snap();
        sendByte(8'hA5, 1'b1);
        sendByte(8'h00, 1'b1);
        sendByte(8'h11, 1'b1);
        sendByte(8'h22, 1'b1);
        rx = 1'b0;
        repeat (4*CPB) @(posedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        checkResetOutputs("midreset");
        checkOutput("midreset cmd_valid", 32'(nCmdValid - c0), 32'd0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        repeat (2*CPB) @(posedge clk);
        snap();
        applyStimulus(56'hA5_01_DE_AD_BE_EF_39);
        checkOutput("post-reset cmd_valid", 32'(nCmdValid - c0), 32'd1);
        checkOutput("post-reset cmd_error", 32'(nCmdError - e0), 32'd0);
        checkOutput("post-reset cmd_addr",  32'(cmd_addr),       32'd1);
        checkOutput("post-reset cmd_data",  cmd_data,            32'hDEAD_BEEF);

        checkOutput("exclusive/held", 32'(violations), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
